// File: rtl/mux_n_to_1_pipe_pkg.sv
// mux_n_to_1_pipe_pkg: shared constants and the clog2 helper for the pipelined mux
package mux_n_to_1_pipe_pkg;
  localparam int SIZE_DEFAULT = 32;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/mux_n_to_1_pipe_sel.sv
// mux_n_to_1_sel: combinational channel select, zero and flag on out-of-range index
module mux_n_to_1_sel #(
  parameter int SIZE  = 32,
  parameter int NUM   = 4,
  parameter int SEL_W = 2
) (
  input  logic [NUM*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]    select_i,
  output logic [SIZE-1:0]     data_o,
  output logic                range_err_o
);
  logic hit;
  always_comb begin
    data_o = '0;
    hit = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      if (select_i == SEL_W'(k)) begin
        data_o = data_i[k*SIZE +: SIZE];
        hit = 1'b1;
      end
    end
    range_err_o = !hit;
  end
endmodule

// File: rtl/mux_n_to_1_pipe.sv
// mux_n_to_1_pipe: N-to-1 mux feeding a two-entry skid buffer with sticky select error
module mux_n_to_1_pipe
  import mux_n_to_1_pipe_pkg::*;
#(
  parameter int SIZE  = SIZE_DEFAULT,
  parameter int NUM   = 4,
  parameter int SEL_W = clog2(NUM)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]    select_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [SIZE-1:0]     data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [1:0]          count_o,
  output logic                err_o
);
  logic [SIZE-1:0] sel_data, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, err_q, err_d;
  logic sel_err, acc, rel, load_main, load_skid, from_skid;

  mux_n_to_1_sel #(.SIZE(SIZE), .NUM(NUM), .SEL_W(SEL_W)) u_sel (
    .data_i      (data_i),
    .select_i    (select_i),
    .data_o      (sel_data),
    .range_err_o (sel_err)
  );

  // ready_o depends only on registered state, so ready_i never reaches it combinationally
  always_comb begin
    acc       = valid_i & ~skid_v_q;
    rel       = main_v_q & ready_i;
    from_skid = rel & skid_v_q;
    load_main = acc & (~main_v_q | rel);
    load_skid = acc & main_v_q & ~rel;
    main_d    = from_skid ? skid_q : load_main ? sel_data : main_q;
    main_v_d  = from_skid | load_main | (main_v_q & ~rel);
    skid_d    = load_skid ? sel_data : skid_q;
    skid_v_d  = load_skid | (skid_v_q & ~rel);
    err_d     = err_q | (acc & sel_err);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      err_q    <= err_d;
    end
  end

  assign ready_o = ~skid_v_q;
  assign data_o  = main_q;
  assign valid_o = main_v_q;
  assign count_o = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign err_o   = err_q;
endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// tb_mux_n_to_1_pipe: directed and scoreboard checks of the pipelined skid-buffered mux
module tb_mux_n_to_1_pipe;
  logic clk_i = 1'b0;
  logic rst_i;
  logic [127:0] data4;
  logic [1:0] sel4;
  logic valid4, ready4_i, ready4_o, valid4_o, err4;
  logic [31:0] dout4;
  logic [1:0] cnt4;
  logic [159:0] data5;
  logic [2:0] sel5;
  logic valid5, ready5_i, ready5_o, valid5_o, err5;
  logic [31:0] dout5;
  logic [1:0] cnt5;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mux_n_to_1_pipe #(.SIZE(32), .NUM(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data4), .select_i(sel4), .valid_i(valid4),
    .ready_o(ready4_o), .data_o(dout4), .valid_o(valid4_o), .ready_i(ready4_i),
    .count_o(cnt4), .err_o(err4)
  );

  mux_n_to_1_pipe #(.SIZE(32), .NUM(5), .SEL_W(3)) dut5 (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data5), .select_i(sel5), .valid_i(valid5),
    .ready_o(ready5_o), .data_o(dout5), .valid_o(valid5_o), .ready_i(ready5_i),
    .count_o(cnt5), .err_o(err5)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check4(input string name, input logic [31:0] d, input logic v, input logic [1:0] c, input logic r);
    checks++;
    if (dout4 !== d || valid4_o !== v || cnt4 !== c || ready4_o !== r) begin
      errors++;
      $display("FAIL %s: got data=%h valid=%b count=%0d ready=%b, expected data=%h valid=%b count=%0d ready=%b",
               name, dout4, valid4_o, cnt4, ready4_o, d, v, c, r);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    valid4 = 0; sel4 = 0; data4 = '0; ready4_i = 0;
    valid5 = 0; sel5 = 0; data5 = '0; ready5_i = 0;
    #3;
    check4("reset_dut4", 32'h0, 1'b0, 2'd0, 1'b1);
    checks++;
    if (err4 !== 1'b0 || err5 !== 1'b0 || valid5_o !== 1'b0 || ready5_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: err4=%b err5=%b valid5=%b ready5=%b, expected 0 0 0 1", err4, err5, valid5_o, ready5_o);
    end
    #9;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    data4 = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    sel4 = 2'd2; valid4 = 1; ready4_i = 1;
    tick();
    check4("single_out", 32'hDEADBEEF, 1'b1, 2'd1, 1'b1);
    valid4 = 0;
    tick();
    check4("single_drain", 32'hDEADBEEF, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_stream();
    data4 = {32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000};
    ready4_i = 1;
    for (int k = 0; k < 4; k++) begin
      sel4 = 2'(k); valid4 = 1;
      tick();
      check4($sformatf("stream_%0d", k), 32'h10000000 + 32'(k), 1'b1, 2'd1, 1'b1);
    end
    valid4 = 0;
    tick();
    check4("stream_end", 32'h10000003, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    data4 = {32'hCCCC0003, 32'hCCCC0002, 32'hBBBB000B, 32'hAAAA000A};
    ready4_i = 0; valid4 = 1; sel4 = 2'd0;
    tick();
    check4("skid_A", 32'hAAAA000A, 1'b1, 2'd1, 1'b1);
    sel4 = 2'd1;
    tick();
    check4("skid_AB", 32'hAAAA000A, 1'b1, 2'd2, 1'b0);
    sel4 = 2'd2;
    tick();
    check4("skid_full_ignore", 32'hAAAA000A, 1'b1, 2'd2, 1'b0);
    valid4 = 0; ready4_i = 1;
    tick();
    check4("skid_B", 32'hBBBB000B, 1'b1, 2'd1, 1'b1);
    tick();
    check4("skid_empty", 32'hBBBB000B, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_err();
    data5 = {32'h55550004, 32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};
    ready5_i = 1; valid5 = 1; sel5 = 3'd7;
    tick();
    checks++;
    if (dout5 !== 32'h0 || valid5_o !== 1'b1 || err5 !== 1'b1) begin
      errors++;
      $display("FAIL err_set: data=%h valid=%b err=%b, expected 00000000 1 1", dout5, valid5_o, err5);
    end
    sel5 = 3'd4;
    tick();
    checks++;
    if (dout5 !== 32'h55550004 || err5 !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: data=%h err=%b, expected 55550004 1", dout5, err5);
    end
    sel5 = 3'd1;
    tick();
    valid5 = 0;
    checks++;
    if (dout5 !== 32'h55550001 || err5 !== 1'b1 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky2: data=%h err5=%b err4=%b, expected 55550001 1 0", dout5, err5, err4);
    end
  endtask

  task automatic test_async_reset();
    data4 = {32'h0D000003, 32'h0D000002, 32'h0D000001, 32'h0D000000};
    ready4_i = 0; valid4 = 1; sel4 = 2'd0;
    tick();
    sel4 = 2'd1;
    tick();
    valid4 = 0;
    check4("pre_reset_full", 32'h0D000000, 1'b1, 2'd2, 1'b0);
    #1 rst_i = 1'b1;
    #1;
    check4("async_reset", 32'h0, 1'b0, 2'd0, 1'b1);
    checks++;
    if (err5 !== 1'b0 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_err: err4=%b err5=%b, expected 0 0", err4, err5);
    end
    #1 rst_i = 1'b0;
    ready4_i = 1; valid4 = 1; sel4 = 2'd3;
    tick();
    check4("after_reset_accept", 32'h0D000003, 1'b1, 2'd1, 1'b1);
    valid4 = 0;
    tick();
    check4("after_reset_drain", 32'h0D000003, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] prev_d;
    logic prev_stall;
    logic acc, rel;
    int bad;
    prev_stall = 0;
    prev_d = '0;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      checks++;
      if (ready4_o !== (q.size() < 2) || valid4_o !== (q.size() > 0) || cnt4 !== 2'(q.size()) ||
          (q.size() > 0 && dout4 !== q[0]) || (prev_stall && dout4 !== prev_d)) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random_cycle_%0d: data=%h valid=%b count=%0d ready=%b, expected head=%h occupancy=%0d",
                   c, dout4, valid4_o, cnt4, ready4_o, (q.size() > 0) ? q[0] : 32'h0, q.size());
      end
      data4 = {$urandom, $urandom, $urandom, $urandom};
      sel4 = 2'($urandom_range(0, 3));
      valid4 = ($urandom_range(0, 3) != 0);
      ready4_i = ($urandom_range(0, 2) != 0);
      acc = valid4 && q.size() < 2;
      rel = q.size() > 0 && ready4_i;
      prev_stall = q.size() > 0 && !ready4_i;
      prev_d = (q.size() > 0) ? q[0] : 32'h0;
      if (rel) void'(q.pop_front());
      if (acc) q.push_back(data4[sel4*32 +: 32]);
      tick();
    end
    valid4 = 0; ready4_i = 1;
    tick();
    tick();
    check4("random_drain", dout4, 1'b0, 2'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_to_back();
    test_err();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
